// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : ID-stage hazard/forwarding controller for a 5-stage pipeline.
//               Optional performance counters enabled by HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 1,
    parameter int WB_BYPASS  = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_rs,
    input  logic [REG_ADDR_W-1:0] d_rt,
    input  logic                  d_use_rs,
    input  logic                  d_use_rt,
    input  logic                  d_wreg,
    input  logic                  d_m2reg,
    input  logic [REG_ADDR_W-1:0] d_dest,
    input  logic                  flush,
    output logic                  stall,
    output logic                  e_valid,
    output logic                  m_valid,
    output logic                  w_valid,
    output logic [2:0]            fwd_a,
    output logic [2:0]            fwd_b
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    localparam logic [2:0] c_sel_rf  = 3'd0;
    localparam logic [2:0] c_sel_exe = 3'd1;
    localparam logic [2:0] c_sel_mr  = 3'd2;
    localparam logic [2:0] c_sel_mdo = 3'd3;
    localparam logic [2:0] c_sel_wb  = 3'd4;

    logic                  r_e_valid, r_e_wreg, r_e_m2reg;
    logic                  r_m_valid, r_m_wreg, r_m_m2reg;
    logic                  r_w_valid, r_w_wreg;
    logic [REG_ADDR_W-1:0] r_e_dest, r_m_dest, r_w_dest;

    logic [3:0] w_res_a, w_res_b;
    logic       w_stall;
    logic       w_accept;

    function automatic logic stage_hit(input logic v, input logic wr,
                                       input logic [REG_ADDR_W-1:0] dest,
                                       input logic [REG_ADDR_W-1:0] src,
                                       input logic use_x);
        return v & wr & use_x & (dest == src) & ~((ZERO_REG != 0) && (src == '0));
    endfunction

    // Result bit 3 flags a load-use hazard; bits 2:0 are the operand select.
    function automatic logic [3:0] resolve(input logic [REG_ADDR_W-1:0] src,
                                           input logic use_x);
        logic [3:0] r;
        r = {1'b0, c_sel_rf};
        if (stage_hit(r_e_valid, r_e_wreg, r_e_dest, src, use_x))
            r = r_e_m2reg ? {1'b1, c_sel_rf} : {1'b0, c_sel_exe};
        else if (stage_hit(r_m_valid, r_m_wreg, r_m_dest, src, use_x))
            r = {1'b0, (r_m_m2reg ? c_sel_mdo : c_sel_mr)};
        else if (stage_hit(r_w_valid, r_w_wreg, r_w_dest, src, use_x))
            r = {1'b0, ((WB_BYPASS != 0) ? c_sel_wb : c_sel_rf)};
        return r;
    endfunction

    always_comb begin
        w_res_a  = resolve(d_rs, d_use_rs);
        w_res_b  = resolve(d_rt, d_use_rt);
        w_stall  = d_valid & ~flush & (w_res_a[3] | w_res_b[3]);
        w_accept = d_valid & ~w_stall & ~flush;
        fwd_a    = (d_valid & ~w_stall) ? w_res_a[2:0] : c_sel_rf;
        fwd_b    = (d_valid & ~w_stall) ? w_res_b[2:0] : c_sel_rf;
    end

    assign stall   = w_stall;
    assign e_valid = r_e_valid;
    assign m_valid = r_m_valid;
    assign w_valid = r_w_valid;

    // Shadow pipeline: a rejected or absent decode becomes a fully cleared bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_valid <= 1'b0;
            r_e_wreg  <= 1'b0;
            r_e_m2reg <= 1'b0;
            r_e_dest  <= '0;
            r_m_valid <= 1'b0;
            r_m_wreg  <= 1'b0;
            r_m_m2reg <= 1'b0;
            r_m_dest  <= '0;
            r_w_valid <= 1'b0;
            r_w_wreg  <= 1'b0;
            r_w_dest  <= '0;
        end else begin
            r_e_valid <= w_accept;
            r_e_wreg  <= w_accept & d_wreg;
            r_e_m2reg <= w_accept & d_m2reg;
            r_e_dest  <= w_accept ? d_dest : '0;
            r_m_valid <= r_e_valid;
            r_m_wreg  <= r_e_wreg;
            r_m_m2reg <= r_e_m2reg;
            r_m_dest  <= r_e_dest;
            r_w_valid <= r_m_valid;
            r_w_wreg  <= r_m_wreg;
            r_w_dest  <= r_m_dest;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush && d_valid && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = |CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Scoreboard bench for pipe_hazard_ctrl (WB_BYPASS=1 and =0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       d_valid = 1'b0, d_use_rs = 1'b0, d_use_rt = 1'b0;
    logic       d_wreg = 1'b0, d_m2reg = 1'b0, flush = 1'b0;
    logic [4:0] d_rs = '0, d_rt = '0, d_dest = '0;

    logic       stall, e_valid, m_valid, w_valid;
    logic [2:0] fwd_a, fwd_b;
    logic       nb_stall, nb_e_valid, nb_m_valid, nb_w_valid;
    logic [2:0] nb_fwd_a, nb_fwd_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [3:0] stall_cnt, flush_cnt, nb_stall_cnt, nb_flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .ZERO_REG(1), .WB_BYPASS(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_wreg(d_wreg), .d_m2reg(d_m2reg),
        .d_dest(d_dest), .flush(flush), .stall(stall), .e_valid(e_valid),
        .m_valid(m_valid), .w_valid(w_valid), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .ZERO_REG(1), .WB_BYPASS(0), .CNT_W(4)) dut_nb (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_wreg(d_wreg), .d_m2reg(d_m2reg),
        .d_dest(d_dest), .flush(flush), .stall(nb_stall), .e_valid(nb_e_valid),
        .m_valid(nb_m_valid), .w_valid(nb_w_valid), .fwd_a(nb_fwd_a), .fwd_b(nb_fwd_b)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(nb_stall_cnt), .flush_cnt(nb_flush_cnt)
`endif
    );

    typedef struct packed {
        logic [7:0] id;
        logic       st, ev, mv, wv;
        logic [2:0] fa, fb, fan, fbn;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   sid = 0;

    task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %0h expected %0h", id, nm, act, exp);
        end
    endtask

    // Drive one decode cycle and queue the response expected during that cycle.
    task automatic step(input logic rst, input logic dv, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic wr, input logic m2,
                        input logic [4:0] dest, input logic fl,
                        input logic st, input logic ev, input logic mv, input logic wv,
                        input logic [2:0] fa, input logic [2:0] fb,
                        input logic [2:0] fan, input logic [2:0] fbn);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; d_valid = dv; d_rs = rs; d_rt = rt; d_use_rs = urs; d_use_rt = urt;
        d_wreg = wr; d_m2reg = m2; d_dest = dest; flush = fl;
        sid++;
        e.id = 8'(sid); e.st = st; e.ev = ev; e.mv = mv; e.wv = wv;
        e.fa = fa; e.fb = fb; e.fan = fan; e.fbn = fbn;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("stall",   int'(mon_e.id), {7'd0, stall},   {7'd0, mon_e.st});
            chk("e_valid", int'(mon_e.id), {7'd0, e_valid}, {7'd0, mon_e.ev});
            chk("m_valid", int'(mon_e.id), {7'd0, m_valid}, {7'd0, mon_e.mv});
            chk("w_valid", int'(mon_e.id), {7'd0, w_valid}, {7'd0, mon_e.wv});
            chk("fwd_a",   int'(mon_e.id), {5'd0, fwd_a},   {5'd0, mon_e.fa});
            chk("fwd_b",   int'(mon_e.id), {5'd0, fwd_b},   {5'd0, mon_e.fb});
            chk("nb_fwd_a", int'(mon_e.id), {5'd0, nb_fwd_a}, {5'd0, mon_e.fan});
            chk("nb_fwd_b", int'(mon_e.id), {5'd0, nb_fwd_b}, {5'd0, mon_e.fbn});
            chk("nb_ctrl", int'(mon_e.id), {4'd0, nb_stall, nb_e_valid, nb_m_valid, nb_w_valid},
                {4'd0, mon_e.st, mon_e.ev, mon_e.mv, mon_e.wv});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //   rst dv rs  rt urs urt wr m2 dest fl | st ev mv wv fa fb fan fbn
        step(0, 0, 0,  0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0,  0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0,  0, 0, 0, 1, 0, 1,  0,   0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0,  0, 0, 0, 1, 0, 2,  0,   0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0,  0, 0, 0, 1, 0, 4,  0,   0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 4,  0, 1, 0, 0, 0, 0,  0,   0, 1, 1, 1, 0, 0, 0, 0);
        // asynchronous reset mid-stream, then release with idle decode
        step(0, 0, 0,  0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 4,  2, 1, 1, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 4,  2, 1, 1, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 4,  2, 1, 1, 0, 0, 0,  0,   0, 0, 0, 0, 0, 0, 0, 0);
        // ALU chain on r3
        step(1, 1, 0,  0, 0, 0, 1, 0, 3,  0,   0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3,  0, 1, 0, 0, 0, 0,  0,   0, 1, 1, 0, 1, 0, 1, 0);
        step(1, 1, 3,  0, 1, 0, 0, 0, 0,  0,   0, 1, 1, 1, 2, 0, 2, 0);
        step(1, 1, 3,  0, 1, 0, 0, 0, 0,  0,   0, 1, 1, 1, 4, 0, 0, 0);
        // load-use on r5, then independent operands from EXE and WB
        step(1, 1, 0,  0, 0, 0, 1, 1, 5,  0,   0, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 5,  6, 1, 1, 1, 0, 8,  0,   1, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 5,  6, 1, 1, 1, 0, 8,  0,   0, 0, 1, 1, 3, 0, 3, 0);
        step(1, 1, 8,  5, 1, 1, 0, 0, 0,  0,   0, 1, 0, 1, 1, 4, 1, 0);
        // zero register: ALU write then load write of r0
        step(1, 1, 0,  0, 0, 0, 1, 0, 0,  0,   0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0,  0, 1, 1, 1, 1, 0,  0,   0, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 0,  0, 1, 1, 0, 0, 0,  0,   0, 1, 1, 1, 0, 0, 0, 0);
        // priority: r7 in EXE and MEM
        step(1, 1, 0,  0, 0, 0, 1, 0, 7,  0,   0, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 0,  0, 0, 0, 1, 0, 7,  0,   0, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 7,  7, 0, 1, 0, 0, 0,  0,   0, 1, 1, 1, 0, 1, 0, 1);
        // flush beats a pending load-use
        step(1, 1, 0,  0, 0, 0, 1, 1, 9,  0,   0, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 9,  0, 1, 0, 0, 0, 0,  1,   0, 1, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0,  0, 0, 0, 0, 0, 0,  0,   0, 0, 1, 1, 0, 0, 0, 0);
        // both operands hit one load: single stall
        step(1, 1, 0,  0, 0, 0, 1, 1, 10, 0,   0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 1, 10, 10, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 10, 10, 1, 1, 0, 0, 0, 0,   0, 0, 1, 0, 3, 3, 3, 3);
        step(1, 0, 0,  0, 0, 0, 0, 0, 0,  0,   0, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0,  0, 0, 0, 0, 0, 0,  0,   0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0,  0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 1, 0, 0, 0, 0);
        // 20 load-use pairs: load, stalled use, resolved use
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0,  0, 0, 0, 1, 1, 11, 0, 0, (i > 0), 0, (i > 0), 0, 0, 0, 0);
            step(1, 1, 11, 0, 1, 0, 0, 0, 0,  0, 1, 1, (i > 0), 0, 0, 0, 0, 0);
            step(1, 1, 11, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1, (i > 0), 3, 0, 3, 0);
        end
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        chk("scoreboard_drain", 0, 8'(q.size()), 8'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt_sat", 0, {4'd0, stall_cnt}, 8'd15);
        chk("flush_cnt", 0, {4'd0, flush_cnt}, 8'd1);
        chk("nb_stall_cnt_sat", 0, {4'd0, nb_stall_cnt}, 8'd15);
        chk("nb_flush_cnt", 0, {4'd0, nb_flush_cnt}, 8'd1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined datapath (IF, ID, EXE, MEM, WB).
- Keeps a shadow pipeline of valid, wreg, m2reg and destination register for the EXE, MEM and WB stages.
- Generates ID-stage operand forwarding selects, load-use stall and bubble insertion, and squashes the decode instruction on redirect.
- Sits beside the ID stage: its outputs drive the qa/qb forwarding muxes, PC/IF-ID write enables and EXE-stage valid gating.

Parameters:
- REG_ADDR_W, 5: register index width; 2**REG_ADDR_W architectural registers.
- ZERO_REG, 1: 1 = register 0 is hardwired zero, never matched for forwarding or stall.
- WB_BYPASS, 1: 1 = forward the WB-stage result to ID (register file is not write-through); 0 = register file write-through, no WB match.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- d_valid  in  1  ID stage holds a valid instruction
- d_rs  in  REG_ADDR_W  ID source register A
- d_rt  in  REG_ADDR_W  ID source register B
- d_use_rs  in  1  instruction reads rs
- d_use_rt  in  1  instruction reads rt
- d_wreg  in  1  instruction writes the register file
- d_m2reg  in  1  instruction is a load
- d_dest  in  REG_ADDR_W  destination register (post regrt mux)
- flush  in  1  redirect; squash the ID instruction this cycle
- stall  out  1  hold PC and IF/ID register; combinational
- e_valid  out  1  EXE stage valid; gates ewreg/ewmem
- m_valid  out  1  MEM stage valid
- w_valid  out  1  WB stage valid
- fwd_a  out  3  qa source: 0 regfile, 1 EXE alu r, 2 MEM mr, 3 MEM mdo, 4 WB result
- fwd_b  out  3  qb source, same encoding as fwd_a

Behaviour:
- Reset (async, rst_n=0): E/M/W valid, wreg, m2reg and dest cleared to 0.
  - Outputs during reset: stall=0, fwd_a=fwd_b=0, e/m/w_valid=0.
  - Reset mid-operation squashes all in-flight instructions. No write is reported after release until new instructions advance.
- Stage match for operand X: stage valid & wreg & dest==X & use_X & ~(ZERO_REG & X==0).
- Priority is youngest first: EXE, then MEM, then WB.
  - EXE match, non-load: sel=1.
  - EXE match, load (m2reg): load-use hazard, stall request.
  - MEM match: sel=3 if m2reg, else 2.
  - WB match: sel=4 if WB_BYPASS, else 0.
  - No match: sel=0.
- stall = d_valid & ~flush & (load-use on rs or rt).
  - While stall=1: fwd_a=fwd_b=0.
  - Stall lasts exactly one cycle per load-use. The load then sits in MEM and sel=3 applies.
- Shadow pipeline update on every rising clk (no global enable):
  - E takes the decode fields when d_valid & ~stall & ~flush; otherwise E becomes a bubble (valid=0, wreg=0, m2reg=0, dest=0).
  - M <= E; W <= M.
- Latency: an accepted decode instruction shows e_valid=1 one cycle later, m_valid two cycles later, w_valid three cycles later.
- flush and load-use in the same cycle: flush wins, stall=0, and a bubble enters E.
- d_valid=0: stall=0, fwd=0, bubble enters E.
- Both operands matching different stages are resolved independently. Both matching a load in EXE gives a single one-cycle stall.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt and flush_cnt, each CNT_W bits, zeroed on reset.
  - stall_cnt increments on each cycle with stall=1.
  - flush_cnt increments on each cycle with flush & d_valid.
  - Both saturate at all-ones.
- Undefined: ports and counter logic are absent. Core behaviour is identical either way.

Test Plan:
- Reset: hold rst_n=0 mid-stream with e/m/w_valid=1, then release with d_valid=0 -> all valids 0, stall=0, fwd_a=fwd_b=0 for 3 cycles.
- ALU chain: cycle0 decode dest=3, wreg=1. Cycles 1/2/3 decode rs=3 -> fwd_a=1, then 2, then 4 (WB_BYPASS=1); then 0 with WB_BYPASS=0.
- Load-use: cycle0 load dest=5, cycle1 decode rs=5 -> stall=1 in cycle1. Cycle2 shows e_valid=0, stall=0, fwd_a=3.
- Zero register: ZERO_REG=1, write r0 then read rs=0, rt=0 -> fwd_a=fwd_b=0, no stall even when r0 comes from a load.
- Priority: EXE and MEM both write r7 (non-load), decode rt=7 -> fwd_b=1. Flush with a load-use pending -> stall=0, next e_valid=0, flush_cnt +1 when HAZARD_PERF_CNT_EN is defined.
- Counter saturation with HAZARD_PERF_CNT_EN defined and CNT_W=4: 20 load-use stalls -> stall_cnt=15 held.
